// File: rtl/shared_timer_arbiter_pkg.sv
// Shared types and default sizing for the shared interval-timer scheduler.
package timer_arb_pkg;
  localparam int DEF_NREQ = 4;
  localparam int DEF_N    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/shared_timer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);
  int j;

  // Scan farthest-first so the nearest candidate after ptr is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/shared_timer_arbiter.sv
// Round-robin scheduler sharing one N-bit interval counter among NREQ requesters.
//
// state | meaning
// IDLE  | counter free; arbitrate pending requests
// LOAD  | winner latched, counter cleared
// RUN   | count ticks until count == latched max
// DONE  | one-cycle done pulse to the owner, release grant
module shared_timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int N    = DEF_N
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] dur,
  input  logic              tick,
  input  logic              abort,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [N-1:0]      count,
  output logic              at_max
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nxt;
  logic [N-1:0]    count_nxt;
  logic [N-1:0]    max_q, max_nxt;
  logic [IW-1:0]   idx_q, idx_nxt;
  logic [IW-1:0]   ptr_q, ptr_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic            arb_valid;
  logic [IW-1:0]   arb_idx;
  logic            cancel;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr_arbiter (
    .req   (req),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      count <= '0;
      grant <= '0;
      max_q <= '0;
      idx_q <= '0;
      ptr_q <= IW'(NREQ - 1);
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      grant <= grant_nxt;
      max_q <= max_nxt;
      idx_q <= idx_nxt;
      ptr_q <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    grant_nxt = grant;
    max_nxt   = max_q;
    idx_nxt   = idx_q;
    ptr_nxt   = ptr_q;
    cancel    = ((state == LOAD) || (state == RUN)) && (abort || !req[idx_q]);

    case (state)
      IDLE: begin
        if (arb_valid) begin
          idx_nxt   = arb_idx;
          max_nxt   = dur[arb_idx*N +: N];
          grant_nxt = NREQ'(1) << arb_idx;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        count_nxt = '0;
        state_nxt = RUN;
      end
      RUN: begin
        if (tick) begin
          if (count == max_q) state_nxt = DONE;
          else                count_nxt = count + N'(1);
        end
      end
      DONE: begin
        grant_nxt = '0;
        ptr_nxt   = idx_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Cancellation overrides any tick handled above in the same cycle.
    if (cancel) begin
      state_nxt = IDLE;
      grant_nxt = '0;
      ptr_nxt   = idx_q;
      count_nxt = '0;
    end

    done   = (state == DONE) ? grant : '0;
    busy   = (state != IDLE);
    at_max = busy && (count == max_q);
  end
endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Scenario bench for shared_timer_arbiter with a done-pulse scoreboard.
module tb_shared_timer_arbiter;
  localparam int NREQ = 4;
  localparam int N    = 4;

  logic              clk = 1'b0;
  logic              nrst;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] dur;
  logic              tick;
  logic              abort;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [N-1:0]      count;
  logic              at_max;

  int checks = 0;
  int fails  = 0;
  bit mon_en = 1'b0;
  logic [NREQ-1:0] exp_done[$];
  logic [NREQ-1:0] exp_grant[$];

  shared_timer_arbiter #(.NREQ(NREQ), .N(N)) dut (
    .clk(clk), .nrst(nrst), .req(req), .dur(dur), .tick(tick), .abort(abort),
    .grant(grant), .done(done), .busy(busy), .count(count), .at_max(at_max)
  );

  always #5 clk = ~clk;

  // Every done pulse must match the next expected owner and be covered by grant.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((done & ~grant) !== '0) begin
        fails++;
        $display("FAIL done_within_grant: done=%b grant=%b", done, grant);
      end
      if (done !== '0) begin
        checks++;
        if (exp_done.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: done=%b, none expected", done);
        end else begin
          logic [NREQ-1:0] e;
          e = exp_done.pop_front();
          if (done !== e) begin
            fails++;
            $display("FAIL done_owner: got %b expected %b", done, e);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (done !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (grant !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    nrst = 1'b0; req = 4'b1111; dur = '0; tick = 1'b0; abort = 1'b0;
    cyc();
    cyc();
    mon_en = 1'b1;
    checks++;
    if ({grant, done, busy, count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: grant=%b done=%b busy=%b count=%0d, all zero expected",
               grant, done, busy, count);
    end
    nrst = 1'b1;
    cyc();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      fails++;
      $display("FAIL first_grant: grant=%b busy=%b expected 0001/1", grant, busy);
    end
    exp_done.push_back(4'b0001);
    req = 4'b0001; tick = 1'b1;
    wait_done(20, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL reset_first_done: timeout, done never seen"); end
    req = '0; tick = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    bit ok;
    req = 4'b0100; dur = 16'h0300; tick = 1'b1;
    cyc();
    checks++;
    if (grant !== 4'b0100) begin
      fails++;
      $display("FAIL single_grant: grant=%b expected 0100", grant);
    end
    exp_done.push_back(4'b0100);
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (count !== N'(k) || done !== '0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL single_count: count=%0d done=%b busy=%b expected %0d/0000/1",
                 count, done, busy, k);
      end
    end
    cyc();
    checks++;
    if (done !== 4'b0100 || count !== 4'd3 || at_max !== 1'b1) begin
      fails++;
      $display("FAIL single_done: done=%b count=%0d at_max=%b expected 0100/3/1",
               done, count, at_max);
    end
    req = '0;
    cyc();
    checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      fails++;
      $display("FAIL single_release: busy=%b grant=%b expected 0/0000", busy, grant);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    nrst = 1'b0; req = '0; tick = 1'b0;
    cyc();
    nrst = 1'b1;
    exp_grant = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    foreach (exp_grant[i]) exp_done.push_back(exp_grant[i]);
    req = 4'b1011; dur = '0; tick = 1'b1;
    for (int n = 0; n < 4; n++) begin
      logic [NREQ-1:0] e;
      wait_grant(10, ok);
      e = exp_grant.pop_front();
      checks++;
      if (!ok || grant !== e) begin
        fails++;
        $display("FAIL rr_grant_%0d: grant=%b expected %b", n, grant, e);
      end
      wait_done(10, ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL rr_done_%0d: timeout, done never seen", n); end
    end
    req = '0;
    cyc();
  endtask

  task automatic test_gapped_max0();
    req = 4'b0010; dur = '0; tick = 1'b0;
    cyc();
    checks++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL gap_grant: grant=%b expected 0010", grant);
    end
    exp_done.push_back(4'b0010);
    cyc();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy !== 1'b1 || at_max !== 1'b1 || count !== '0 || done !== '0) begin
        fails++;
        $display("FAIL gap_run_%0d: busy=%b at_max=%b count=%0d done=%b expected 1/1/0/0000",
                 c, busy, at_max, count, done);
      end
      tick = (c == 2);
      cyc();
    end
    checks++;
    if (done !== 4'b0010 || count !== '0) begin
      fails++;
      $display("FAIL gap_done: done=%b count=%0d expected 0010/0", done, count);
    end
    tick = 1'b0; req = '0;
    cyc();
  endtask

  task automatic test_cancel();
    bit ok;
    req = 4'b0011; dur = 16'h0007; tick = 1'b1;
    cyc();
    checks++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("FAIL cancel_grant: grant=%b expected 0001", grant);
    end
    for (int k = 0; k < 6; k++) cyc();
    checks++;
    if (count !== 4'd5) begin
      fails++;
      $display("FAIL cancel_pre_count: count=%0d expected 5", count);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++;
    if (grant !== '0 || count !== '0 || busy !== 1'b0 || done !== '0) begin
      fails++;
      $display("FAIL cancel_state: grant=%b count=%0d busy=%b done=%b expected 0000/0/0/0000",
               grant, count, busy, done);
    end
    cyc();
    checks++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL cancel_next_grant: grant=%b expected 0010", grant);
    end
    exp_done.push_back(4'b0010);
    req = 4'b0010;
    wait_done(10, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL cancel_follow_done: timeout, done never seen"); end
    req = '0;
    cyc();
  endtask

  task automatic test_late_dur_and_reset();
    bit ok;
    int n;
    req = 4'b1000; dur = 16'h2000; tick = 1'b1;
    cyc();
    checks++;
    if (grant !== 4'b1000) begin
      fails++;
      $display("FAIL late_grant: grant=%b expected 1000", grant);
    end
    exp_done.push_back(4'b1000);
    cyc();
    dur = 16'h9000;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n++;
      if (done !== '0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || n != 3) begin
      fails++;
      $display("FAIL late_dur_ticks: took %0d cycles (seen=%0b) expected 3", n, ok);
    end
    req = '0;
    cyc();
    req = 4'b1000;
    cyc();
    cyc();
    cyc();
    checks++;
    if (count !== 4'd1) begin
      fails++;
      $display("FAIL midrst_pre_count: count=%0d expected 1", count);
    end
    nrst = 1'b0;
    cyc();
    checks++;
    if ({grant, done, busy, count, at_max} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: grant=%b done=%b busy=%b count=%0d at_max=%b expected zeros",
               grant, done, busy, count, at_max);
    end
    nrst = 1'b1; req = '0;
    cyc();
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_gapped_max0();
    test_cancel();
    test_late_dur_and_reset();
    checks++;
    if (exp_done.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected done pulses never arrived", exp_done.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/shared_timer_arbiter.md
Name: shared_timer_arbiter

Overview:
- Shares one N-bit interval counter among NREQ requesters.
- Each requester asks for a timed interval of (dur+1) tick strobes. The block grants the counter round-robin, sequences load/run/complete, and returns a one-cycle done pulse to the winner.
- Sits between FPGA test logic (pushbutton or strobe-driven requesters) and the counting datapath. Intended as the scheduler front-end for the existing counter style.

Parameters:
- NREQ, 4, number of requesters (2..8)
- N, 4, counter width in bits; max interval is 2^N ticks

Ports:
- clk  input  1  system clock
- nrst  input  1  reset; synchronous, active-low (sampled on posedge clk)
- req  input  NREQ  per-requester request level; must stay high until done or cancel
- dur  input  NREQ*N  packed durations; requester i uses dur[i*N +: N]
- tick  input  1  count-enable strobe; one count step per cycle where tick=1
- abort  input  1  cancels the active interval
- grant  output  NREQ  one-hot, registered; owner of the counter
- done  output  NREQ  one-cycle pulse to the owner when its interval completes
- busy  output  1  high in LOAD, RUN, DONE
- count  output  N  current counter value
- at_max  output  1  high when busy and count == latched max

Behaviour:
- Reset (nrst=0 at posedge clk):
  - state=IDLE, count=0, grant=0, done=0, busy=0, latched max=0, rr pointer=NREQ-1 (requester 0 has first priority).
  - Reset mid-operation abandons the interval with no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If req != 0, select the first set req bit searching from pointer+1 upward, wrapping modulo NREQ.
  - Latch idx and max=dur[idx]; grant<=onehot(idx); go to LOAD.
  - Otherwise stay in IDLE.
  - Latency req->grant: 1 cycle.
- LOAD: count<=0; go to RUN. Ticks during LOAD are ignored.
- RUN:
  - tick=1 and count==max: go to DONE; count holds at max.
  - tick=1 and count!=max: count<=count+1.
  - tick=0: hold.
  - An interval therefore consumes exactly max+1 ticks in RUN; max=0 completes on the first tick.
- DONE:
  - done[idx]=1 for exactly this cycle.
  - grant<=0, pointer<=idx, go to IDLE.
- Cancel:
  - Condition: in LOAD or RUN, abort=1 or req[idx]=0.
  - Action: go to IDLE next cycle, grant<=0, pointer<=idx, no done pulse, count<=0.
  - Cancel has priority over tick in the same cycle.
  - abort is ignored in IDLE and DONE.
- dur is sampled only at the IDLE->LOAD transition; later changes have no effect on the active interval.
- Requests arriving during LOAD/RUN/DONE wait for arbitration in IDLE.
- Minimum gap between consecutive grants is 1 IDLE cycle. Per-grant overhead is IDLE, LOAD, DONE = 3 cycles plus ticks.
- Fairness: a requester holding req continuously is granted within NREQ-1 other intervals.
- count width is N with no overflow. count never exceeds max because the RUN transition to DONE precedes increment.
- grant and done are mutually consistent: done[i] is only ever set while grant[i] is set.

Decomposition:
- Shared package (timer_arb_pkg): state enum {IDLE, LOAD, RUN, DONE} as a 2-bit typedef, plus localparam defaults for NREQ and N.
- One natural sub-module: rr_arbiter. It is purely combinational, taking (req, pointer) and returning (valid, idx). The FSM, counter and latches remain in shared_timer_arbiter.

Test Plan:
- Reset check: nrst=0 for 2 cycles with req=4'b1111 -> grant=0, done=0, busy=0, count=0. First grant after release is 4'b0001.
- Single request: req=4'b0100, dur[2]=3, tick held 1 -> grant=4'b0100 one cycle after req. count runs 0,1,2,3. done[2] pulses once after the 4th RUN tick. busy drops the next cycle.
- Round-robin: req=4'b1011 held, all dur=0, tick=1 -> grant sequence 0001, 0010, 1000, 0001. Each requester receives exactly one done per grant.
- Gapped ticks and max=0: dur[1]=0, tick pulsed every 3rd cycle -> done[1] follows the first tick in RUN. count stays 0. at_max=1 throughout RUN.
- Cancel: dur[0]=7, abort=1 with tick=1 when count=5 -> no done. Next cycle grant=0 and count=0. With req=4'b0011 the next grant is 4'b0010.
- Late dur change and mid-run reset: change dur[3] from 2 to 9 during RUN -> interval still 3 ticks. Assert nrst=0 at count=1 of a new interval -> all outputs return to reset values on the next edge, with no done pulse.
